// File: rtl/bmp_pkg.sv
// bmp_pkg: shared BMP constants, header field offsets, FSM state type and header ROM function.
package bmp_pkg;
    localparam int unsigned BMP_HEADER_SIZE = 54;
    localparam int unsigned BMP_DIB_SIZE    = 40;
    localparam int unsigned BMP_BPP         = 24;
    localparam int unsigned BMP_PPM         = 2835;

    localparam int unsigned OFF_FILE_SIZE   = 2;
    localparam int unsigned OFF_RESERVED    = 6;
    localparam int unsigned OFF_DATA_OFS    = 10;
    localparam int unsigned OFF_DIB_SIZE    = 14;
    localparam int unsigned OFF_WIDTH       = 18;
    localparam int unsigned OFF_HEIGHT      = 22;
    localparam int unsigned OFF_PLANES      = 26;
    localparam int unsigned OFF_COMPRESSION = 30;
    localparam int unsigned OFF_IMAGE_SIZE  = 34;
    localparam int unsigned OFF_XPPM        = 38;
    localparam int unsigned OFF_CLR_USED    = 46;

    typedef enum logic [1:0] {IDLE, HEADER, PIXELS, DONE} state_t;

    function automatic int unsigned bmp_image_bytes(input int unsigned width, input int unsigned height);
        return ((width * 3 + 3) / 4) * 4 * height;
    endfunction

    // Every field starts at 2 mod 4, so planes+bpp form one 32-bit word at OFF_PLANES.
    function automatic logic [7:0] bmp_header_byte(input logic [5:0] idx, input int unsigned width,
                                                   input int unsigned height);
        int unsigned i;
        int unsigned f;
        int unsigned img;
        i   = 32'(idx);
        img = bmp_image_bytes(width, height);
        if (i < OFF_FILE_SIZE) return i == 0 ? 8'h42 : 8'h4D;
        f = i < OFF_RESERVED    ? BMP_HEADER_SIZE + img :
            i < OFF_DATA_OFS    ? 0 :
            i < OFF_DIB_SIZE    ? BMP_HEADER_SIZE :
            i < OFF_WIDTH       ? BMP_DIB_SIZE :
            i < OFF_HEIGHT      ? width :
            i < OFF_PLANES      ? height :
            i < OFF_COMPRESSION ? (BMP_BPP << 16) | 1 :
            i < OFF_IMAGE_SIZE  ? 0 :
            i < OFF_XPPM        ? img :
            i < OFF_CLR_USED    ? BMP_PPM : 0;
        return 8'(f >> (8 * ((i - OFF_FILE_SIZE) % 4)));
    endfunction
endpackage

// File: rtl/bmp_word_serializer.sv
// bmp_word_serializer: pops 32-bit words from the source FIFO and emits them byte0-first.
module bmp_word_serializer
    import bmp_pkg::*;
#(
    parameter int unsigned WORDS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        fifo_empty_i,
    output logic        fifo_rd_en_o,
    input  logic [31:0] fifo_dout_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        last_o
);
    localparam int WW = $clog2(WORDS + 1);

    logic [31:0]   buf_q, buf_d;
    logic          bv_q, bv_d, infl_q, infl_d;
    logic [1:0]    lane_q, lane_d;
    logic [WW-1:0] left_q, left_d;
    logic          hs;

    assign hs           = bv_q & ready_i;
    assign fifo_rd_en_o = !clr_i & !fifo_empty_i & !infl_q & (left_q != '0) &
                          (!bv_q | (hs & lane_q == 2'd3));
    assign valid_o      = bv_q;
    assign data_o       = bv_q ? buf_q[{lane_q, 3'b000} +: 8] : 8'd0;
    assign last_o       = bv_q & lane_q == 2'd3 & left_q == '0;

    always_comb begin
        buf_d  = buf_q;
        bv_d   = bv_q;
        lane_d = lane_q;
        infl_d = fifo_rd_en_o;
        left_d = fifo_rd_en_o ? left_q - WW'(1) : left_q;
        if (clr_i) begin
            bv_d   = 1'b0;
            infl_d = 1'b0;
            lane_d = 2'd0;
            left_d = WORDS[WW-1:0];
        end else if (infl_q) begin
            buf_d  = fifo_dout_i;
            bv_d   = 1'b1;
            lane_d = 2'd0;
        end else if (hs) begin
            lane_d = lane_q + 2'd1;
            bv_d   = lane_q != 2'd3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q  <= '0;
            bv_q   <= 1'b0;
            infl_q <= 1'b0;
            lane_q <= 2'd0;
            left_q <= '0;
        end else begin
            buf_q  <= buf_d;
            bv_q   <= bv_d;
            infl_q <= infl_d;
            lane_q <= lane_d;
            left_q <= left_d;
        end
    end
endmodule

// File: rtl/bmp_frame_writer.sv
// bmp_frame_writer: streams a 24-bit BMP file (header + pixel words) as bytes over valid/ready.
// BMP_HEADER_EN defined prepends the 54-byte header; undefined emits the raw pixel stream only.
module bmp_frame_writer
    import bmp_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 720,
    parameter int unsigned IMG_HEIGHT = 540
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [31:0] fifo_dout,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);
    localparam int unsigned WORDS = bmp_image_bytes(IMG_WIDTH, IMG_HEIGHT) / 4;

    state_t     state_q;
    logic       busy_q, done_q;
    logic [7:0] ser_data;
    logic       ser_valid, ser_last;

    bmp_word_serializer #(.WORDS(WORDS)) u_ser (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (state_q != PIXELS),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_en_o (fifo_rd_en),
        .fifo_dout_i  (fifo_dout),
        .data_o       (ser_data),
        .valid_o      (ser_valid),
        .ready_i      (out_ready),
        .last_o       (ser_last)
    );

`ifdef BMP_HEADER_EN
    logic [5:0] hdr_idx_q;
    assign out_valid = state_q == HEADER | ser_valid;
    assign out_data  = state_q == HEADER ? bmp_header_byte(hdr_idx_q, IMG_WIDTH, IMG_HEIGHT) : ser_data;
`else
    assign out_valid = ser_valid;
    assign out_data  = ser_data;
`endif
    assign out_last = state_q == PIXELS & ser_last;
    assign busy     = busy_q;
    assign done     = done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef BMP_HEADER_EN
            hdr_idx_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    busy_q    <= 1'b1;
`ifdef BMP_HEADER_EN
                    state_q   <= HEADER;
                    hdr_idx_q <= '0;
`else
                    state_q   <= PIXELS;
`endif
                end
`ifdef BMP_HEADER_EN
                HEADER: if (out_ready) begin
                    hdr_idx_q <= hdr_idx_q + 6'd1;
                    if (hdr_idx_q == 6'(BMP_HEADER_SIZE - 1)) state_q <= PIXELS;
                end
`endif
                PIXELS: if (out_last & out_ready) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bmp_frame_writer.sv
// tb_bmp_frame_writer: scoreboard bench for a 3x2 image; byte stream checked against an independent model.
module tb_bmp_frame_writer;
`ifdef BMP_HEADER_EN
    localparam int HDR = 54;
`else
    localparam int HDR = 0;
`endif
    localparam int TOTAL = HDR + 24;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, out_ready = 1'b1;
    logic        fifo_empty, fifo_rd_en, out_valid, out_last, busy, done;
    logic [31:0] fifo_dout = '0;
    logic [7:0]  out_data;

    bmp_frame_writer #(.IMG_WIDTH(3), .IMG_HEIGHT(2)) dut (
        .clk(clk), .reset(reset), .start(start), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    int wp = 0, rp = 0, rd_cnt = 0;
    assign fifo_empty = (wp == rp);
    always @(posedge clk) if (fifo_rd_en) begin
        fifo_dout <= mem[rp % 64];
        rp        <= rp + 1;
        rd_cnt    <= rd_cnt + 1;
    end

    int n_chk = 0, n_pass = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] hdr [54];
    int byte_cnt = 0, done_cnt = 0, base_b = 0, base_d = 0, base_r = 0, rdy_mode = 0;
    logic stall_q = 1'b0, last_q = 1'b0, held_l = 1'b0;
    logic [7:0] held_d = '0;

    always @(negedge clk) begin
        if (!reset) begin
            stall_q = 1'b0;
            last_q  = 1'b0;
        end else begin
            if (last_q) check("done_pulse", done, 1);
            if (stall_q) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held_d);
                check("hold_last", out_last, held_l);
            end
            if (fifo_rd_en) check("rd_while_empty", fifo_empty, 0);
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_byte", out_valid, 0);
                else check("byte", out_data, exp_q.pop_front());
                check("last", out_last, (byte_cnt - base_b) == TOTAL - 1);
                byte_cnt++;
            end
            stall_q = out_valid && !out_ready;
            held_d  = out_data;
            held_l  = out_last;
            last_q  = out_valid && out_ready && out_last;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rdy_mode == 1 ? ~out_ready : 1'b1;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic put32(input int o, input logic [31:0] v);
        for (int k = 0; k < 4; k++) hdr[o + k] = v[8*k +: 8];
    endtask

    task automatic push_word(input logic [31:0] w, input bit expect_it);
        mem[wp % 64] = w;
        wp++;
        if (expect_it) for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
    endtask

    task automatic new_frame(input int nwords);
        wp = rp;
        exp_q.delete();
        base_b = byte_cnt;
        base_d = done_cnt;
        base_r = rd_cnt;
        for (int i = 0; i < HDR; i++) exp_q.push_back(hdr[i]);
        for (int i = 0; i < nwords; i++) push_word($urandom, 1'b1);
    endtask

    task automatic pulse_start();
        check("busy_idle", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_rise", busy, 1);
    endtask

    task automatic wait_bytes(input int n);
        int t = 0;
        while (byte_cnt - base_b < n && t < 2000) begin tick(); t++; end
        check("reach_byte", byte_cnt - base_b, n);
    endtask

    task automatic finish_frame();
        int t = 0;
        while (done_cnt - base_d < 1 && t < 3000) begin tick(); t++; end
        tick(3);
        check("bytes", byte_cnt - base_b, TOTAL);
        check("rd_pulses", rd_cnt - base_r, 6);
        check("done_count", done_cnt - base_d, 1);
        check("exp_left", exp_q.size(), 0);
        check("busy_end", busy, 0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, fifo_rd_en, 0);
    endtask

    initial begin
        for (int i = 0; i < 54; i++) hdr[i] = 8'h00;
        hdr[0] = 8'h42;
        hdr[1] = 8'h4D;
        put32(2, 78);
        put32(10, 54);
        put32(14, 40);
        put32(18, 3);
        put32(22, 2);
        hdr[26] = 8'd1;
        hdr[28] = 8'd24;
        put32(34, 24);
        put32(38, 2835);
        put32(42, 2835);

        tick(3);
        check_quiet("reset");
        reset = 1'b1;
        tick(2);

        new_frame(6);
        push_word(32'hDEADBEEF, 1'b0);
        pulse_start();
        finish_frame();
        check("extra_word_kept", wp - rp, 1);

        rdy_mode = 1;
        new_frame(6);
        pulse_start();
        finish_frame();
        rdy_mode = 0;
        tick(2);

        new_frame(3);
        pulse_start();
        wait_bytes(HDR + 12);
        tick(20);
        check("pause_bytes", byte_cnt - base_b, HDR + 12);
        check("pause_valid", out_valid, 0);
        for (int i = 0; i < 3; i++) push_word($urandom, 1'b1);
        finish_frame();

        new_frame(6);
        pulse_start();
        wait_bytes(HDR + 6);
        reset = 1'b0;
        tick();
        check_quiet("abort");
        tick(2);
        reset = 1'b1;
        tick(3);
        check("no_done_abort", done_cnt - base_d, 0);
        new_frame(6);
        pulse_start();
        finish_frame();

        new_frame(6);
        pulse_start();
        wait_bytes(HDR + 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_frame();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
